// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Read data returned to a requester whose access was abandoned by the watchdog.
  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;
  localparam int          ARB_CNT_W      = 8;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait counter for the arbiter: counts BUSY cycles without mem_ack and flags expiry
// once the count has reached TIMEOUT_CYCLES.
module arb_timeout_ctr
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam logic [ARB_CNT_W-1:0] LIMIT = ARB_CNT_W'(TIMEOUT_CYCLES);

  logic [ARB_CNT_W-1:0] cnt;

  // Held at zero outside BUSY so every new access starts counting from zero;
  // saturates at the limit so it can never wrap back below it.
  always_ff @(posedge clk) begin
    if (reset || !busy) begin
      cnt <= '0;
    end else if (!ack && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = busy && (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one single-port req/ack memory, data first.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_stall,
  output logic          arb_err
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_t    state, state_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic [DW-1:0] i_rdata_nxt, d_rdata_nxt;
  logic          i_done_nxt, d_done_nxt;
  logic          timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .busy   (state != IDLE),
    .ack    (mem_ack),
    .expired(timeout_hit)
  );

  // An ack arriving in the expiry cycle completes normally, so it does not flag an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_err <= 1'b0;
    end else if (timeout_hit && !mem_ack) begin
      arb_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign arb_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      i_done    <= i_done_nxt;
      d_done    <= d_done_nxt;
    end
  end

  // Requests are only looked at in IDLE, so address/data wiggles during BUSY never
  // reach the memory; the data stage wins ties because it holds the older instruction.
  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (d_req) begin
          state_nxt     = BUSY_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
        end else if (i_req) begin
          state_nxt     = BUSY_I;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = i_addr;
          mem_wdata_nxt = '0;
        end
      end

      BUSY_I: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          i_rdata_nxt = mem_rdata;
          i_done_nxt  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          i_rdata_nxt = DW'(ARB_ABORT_DATA);
          i_done_nxt  = 1'b1;
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          d_rdata_nxt = mem_we ? '0 : mem_rdata;
          d_done_nxt  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          d_rdata_nxt = DW'(ARB_ABORT_DATA);
          d_done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

  assign mem_stall = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a req/ack memory model with programmable
// latency, plus scoreboards of expected read data and expected memory transactions.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_stall;
  logic          arb_err;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  txn_t        txn_q[$];
  txn_t        rsp_txn;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_model [logic [31:0]];

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_stall(mem_stall), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a;
  endfunction

  // Memory side: acks the (ack_delay+1)-th cycle of each mem_req and checks the issued txn.
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      mem_rdata = $urandom;
    end else begin
      if (wait_cnt == ack_delay) begin
        mem_ack = 1'b1;
        if (txn_q.size() == 0) begin
          checkOutput("mem_unexpected_txn", 1, 0);
        end else begin
          rsp_txn = txn_q.pop_front();
          checkOutput("mem_we", mem_we, rsp_txn.we);
          checkOutput("mem_addr", mem_addr, rsp_txn.addr);
          checkOutput("mem_wdata", mem_wdata, rsp_txn.wdata);
        end
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = model_read(mem_addr);
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      wait_cnt++;
    end
  end

  // Completion side: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_done) begin
        if (i_exp_q.size() == 0) checkOutput("i_unexpected_done", 1, 0);
        else checkOutput("i_rdata", i_rdata, i_exp_q.pop_front());
      end
      if (d_done) begin
        if (d_exp_q.size() == 0) checkOutput("d_unexpected_done", 1, 0);
        else checkOutput("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit is_data, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit expect_ack);
    txn_t t;
    if (is_data) begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      if (expect_ack) d_exp_q.push_back(we ? 32'h0 : model_read(addr));
    end else begin
      i_req  = 1'b1;
      i_addr = addr;
      if (expect_ack) i_exp_q.push_back(model_read(addr));
    end
    if (expect_ack) begin
      t.we    = is_data & we;
      t.addr  = addr;
      t.wdata = is_data ? wdata : 32'h0;
      txn_q.push_back(t);
    end
  endtask

  task automatic wait_done(input bit is_data, input int budget, output int req_cycles);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    req_cycles = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (is_data ? d_done : i_done) seen = 1;
      else if (mem_req) req_cycles++;
    end
    if (!seen) checkOutput(is_data ? "d_done_budget" : "i_done_budget", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rc;
    int stall_cnt;
    int high_cnt;
    int n;

    mem_model[32'h0040_0000] = 32'h2010_0005;
    mem_model[32'h0000_0050] = 32'hCAFE_0050;

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_dones", {i_done, d_done}, 0);
    checkOutput("rst_rdata", {i_rdata, d_rdata}, 0);
    checkOutput("rst_arb_err", arb_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Lone fetch, acked in the second cycle of mem_req.
    ack_delay = 1;
    applyStimulus(0, 0, 32'h0040_0000, 0, 1);
    #1 checkOutput("t1_stall_req", mem_stall, 1);
    wait_done(0, 20, rc);
    checkOutput("t1_req_cycles", rc, 2);
    checkOutput("t1_stall_done", mem_stall, 0);
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("t1_idle_after", mem_req, 0);
    checkOutput("t1_rdata_hold", i_rdata, 32'h2010_0005);
    checkOutput("t1_stall_after", mem_stall, 0);

    // Contention: store wins, fetch follows on the next IDLE cycle.
    ack_delay = 0;
    applyStimulus(1, 1, 32'h54, 32'h7, 1);
    applyStimulus(0, 0, 32'h0040_0004, 0, 1);
    #1 checkOutput("t2_stall_req", mem_stall, 1);
    @(negedge clk);
    checkOutput("t2_first_req", mem_req, 1);
    checkOutput("t2_first_we", mem_we, 1);
    checkOutput("t2_first_addr", mem_addr, 32'h54);
    wait_done(1, 20, rc);
    checkOutput("t2_stall_fetch_waiting", mem_stall, 1);
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("t2_fetch_req", mem_req, 1);
    checkOutput("t2_fetch_we", mem_we, 0);
    checkOutput("t2_fetch_addr", mem_addr, 32'h0040_0004);
    wait_done(0, 20, rc);
    i_req = 1'b0;
    @(negedge clk);

    // Load with a slow ack; address changes during the wait must not leak through.
    ack_delay = 5;
    applyStimulus(1, 0, 32'h50, 0, 1);
    stall_cnt = 0;
    #1 if (mem_stall) stall_cnt++;
    n = 0;
    while (!d_done && n < 30) begin
      @(negedge clk);
      n++;
      if (!d_done) begin
        if (mem_stall) stall_cnt++;
        if (mem_req) checkOutput("t3_addr_hold", mem_addr, 32'h50);
        d_addr  = 32'h99 + n;
        d_wdata = 32'h1234_0000 + n;
      end
    end
    if (!d_done) checkOutput("t3_done_budget", 0, 1);
    checkOutput("t3_stall_cycles", stall_cnt, 7);
    d_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a data access.
    ack_delay = 1000;
    applyStimulus(1, 0, 32'h60, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("t4_busy", mem_req, 1);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("t4_mem_req", mem_req, 0);
    checkOutput("t4_mem_addr", mem_addr, 0);
    checkOutput("t4_d_done", d_done, 0);
    checkOutput("t4_rdata", {i_rdata, d_rdata}, 0);
    reset = 1'b0;
    high_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req || d_done) high_cnt++;
    end
    checkOutput("t4_quiet_after", high_cnt, 0);

    // Back-to-back: d_req stays high through d_done with a new address.
    ack_delay = 0;
    applyStimulus(1, 0, 32'h50, 0, 1);
    wait_done(1, 20, rc);
    applyStimulus(1, 0, 32'h54, 0, 1);
    @(negedge clk);
    checkOutput("t5_req_reassert", mem_req, 1);
    checkOutput("t5_addr", mem_addr, 32'h54);
    wait_done(1, 20, rc);
    d_req = 1'b0;
    @(negedge clk);

    // Fetch that is never acknowledged.
    ack_delay = 100000;
`ifdef MEM_ARB_TIMEOUT_EN
    applyStimulus(0, 0, 32'h0040_0008, 0, 0);
    i_exp_q.push_back(32'hDEAD_BEEF);
    wait_done(0, 40, rc);
    i_req = 1'b0;
    checkOutput("t6_req_cycles", rc, TO + 1);
    checkOutput("t6_err_set", arb_err, 1);
    @(negedge clk);
    checkOutput("t6_req_dropped", mem_req, 0);
    ack_delay = 0;
    applyStimulus(0, 0, 32'h0040_0000, 0, 1);
    wait_done(0, 20, rc);
    i_req = 1'b0;
    checkOutput("t6_err_sticky", arb_err, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_err_cleared", arb_err, 0);
`else
    applyStimulus(0, 0, 32'h0040_0008, 0, 0);
    high_cnt = 0;
    repeat (55) begin
      @(negedge clk);
      if (mem_req) high_cnt++;
    end
    checkOutput("t6_wait_forever", high_cnt, 55);
    checkOutput("t6_no_err", arb_err, 0);
    reset = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_reset_abandon", mem_req, 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_i_empty", i_exp_q.size(), 0);
    checkOutput("sb_d_empty", d_exp_q.size(), 0);
    checkOutput("sb_txn_empty", txn_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
